stf_symbol_sequencer: RTL

STF_SYMBOL_SEQUENCER -- requirements
Module: stf_symbol_sequencer

---
 rtl/stf_symbol_sequencer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/stf_symbol_sequencer.sv
// STF symbol sequencer: streams 64-sample STF symbols from a combinational ROM to the IFFT input.
// Optional macro STF_SEQ_FFT_ORDER_EN selects IFFT natural subcarrier order for the ROM address.
module stf_symbol_sequencer #(
  parameter int unsigned SYM_CNT_W = 3
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 abort,
  input  logic [SYM_CNT_W-1:0] num_sym,
  output logic [6:0]           rom_addr,
  input  logic [31:0]          rom_dout,
  output logic [31:0]          out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned IDX_W  = 6;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RUN       = 2'd1,
    S_WAIT_LAST = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     idx, idx_nxt;
  logic [IDX_W-1:0]     idx_map;
  logic [SYM_CNT_W-1:0] sym_cnt, sym_cnt_nxt;
  logic [DATA_W-1:0]    data_nxt;
  logic                 valid_nxt;
  logic                 last_nxt;
  logic                 done_nxt;
  logic                 adv;

  // The output register can take a new sample when empty or draining this cycle.
  assign adv = !out_valid | out_ready;

  // Subcarrier index to ROM address; the ROM itself is stored -32..31.
  always_comb begin
`ifdef STF_SEQ_FFT_ORDER_EN
    idx_map = idx + IDX_W'(32);
`else
    idx_map = idx;
`endif
    rom_addr = (state == S_IDLE) ? 7'd0 : {1'b0, idx_map};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      idx       <= '0;
      sym_cnt   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      sym_cnt   <= sym_cnt_nxt;
      out_data  <= data_nxt;
      out_valid <= valid_nxt;
      out_last  <= last_nxt;
      done      <= done_nxt;
      busy      <= (state_nxt != S_IDLE);
    end
  end

  // Next-state and next-output logic; abort overrides everything else.
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    sym_cnt_nxt = sym_cnt;
    data_nxt    = out_data;
    valid_nxt   = out_valid;
    last_nxt    = out_last;
    done_nxt    = 1'b0;

    if (abort) begin
      state_nxt = S_IDLE;
      valid_nxt = 1'b0;
      last_nxt  = 1'b0;
      idx_nxt   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && (num_sym != '0)) begin
            state_nxt   = S_RUN;
            sym_cnt_nxt = num_sym - SYM_CNT_W'(1);
            idx_nxt     = '0;
          end
        end
        S_RUN: begin
          if (adv) begin
            data_nxt  = rom_dout;
            valid_nxt = 1'b1;
            last_nxt  = (idx == '1);
            idx_nxt   = idx + IDX_W'(1);
            if (idx == '1) begin
              if (sym_cnt != '0) begin
                sym_cnt_nxt = sym_cnt - SYM_CNT_W'(1);
              end else begin
                state_nxt = S_WAIT_LAST;
              end
            end
          end
        end
        S_WAIT_LAST: begin
          if (out_ready) begin
            valid_nxt = 1'b0;
            last_nxt  = 1'b0;
            done_nxt  = 1'b1;
            state_nxt = S_IDLE;
          end
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

endmodule
